pixel_write_scheduler: RTL and testbench
========================================

PIXEL_WRITE_SCHEDULER -- requirements
Module: pixel_write_scheduler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, pixel buffer entries (power of two, >= 2*BURST_LEN).
REQ-002 SHALL have parameter BURST_LEN, default 8, pixels per SDRAM write burst (power of two).
REQ-003 SHALL have parameter COL_BITS, default 10, SDRAM column address width.
REQ-004 SHALL have ports SDRAM_CLK input 1, sole clock (all logic on rising edge); reset_n input 1, asynchronous active-low reset.
REQ-005 SHALL have ports pix_valid input 1, pixel offered; pix_ready output 1, pixel accepted when both high; pix_data input 24, {R,G,B} 8 bits each; pix_sof input 1, first pixel of frame.
REQ-006 SHALL have ports wr_req output 1, burst request; wr_ack input 1, controller accepts request; wr_bank output 2; wr_row output 13; wr_col output COL_BITS.
REQ-007 SHALL have ports wr_data output 24, burst pixel; wr_data_ready input 1, controller consumes wr_data this cycle; wr_busy output 1, burst in progress.
REQ-008 SHALL have port misalign output 1, sticky: pix_sof seen at non-burst-aligned position.

Function
REQ-009 SHALL buffer accepted pixels plus their sof bit in a FIFO_DEPTH-entry FIFO; pix_ready = not full.
REQ-010 SHALL accept and pop in the same cycle when full, without changing count.
REQ-011 SHALL use FSM states IDLE, REQ, DATA.
REQ-012 SHALL move IDLE->REQ when FIFO count >= BURST_LEN.
REQ-013 SHALL hold wr_req high with stable wr_bank/wr_row/wr_col in REQ until wr_ack; REQ->DATA on the wr_ack cycle.
REQ-014 SHALL present FIFO head on wr_data in DATA (zero added latency); pop on each wr_data_ready cycle; DATA->IDLE on the BURST_LEN-th pop.
REQ-015 SHALL ignore wr_data_ready outside DATA and wr_ack outside REQ.
REQ-016 SHALL, on IDLE->REQ, reset address {bank,row,col} to zero if the FIFO head's sof bit is set.
REQ-017 SHALL otherwise advance the address by BURST_LEN after each completed burst: col overflow increments row, row overflow increments bank, bank wraps 3->0.
REQ-018 SHALL set misalign when a popped entry with sof set is not the first of its burst; SHALL clear it only by reset.
REQ-019 SHALL drive wr_busy high in REQ and DATA.

Reset
REQ-020 SHALL, on reset_n low, immediately clear FIFO, address, misalign and counters, and force FSM to IDLE; wr_req=0, wr_busy=0, pix_ready=0 while reset_n low, wr_data=0.
REQ-021 SHALL abandon a burst in progress on reset assertion with no further data beats.
REQ-022 SHALL drive pix_ready=1 from the first clock edge after reset_n release.

Configuration
REQ-023 SHALL, with WSCHED_STATS_EN defined, add outputs burst_count (16 bits, +1 per completed burst) and stall_count (16 bits, +1 per cycle pix_valid=1 while pix_ready=0), both saturating at 16'hFFFF.
REQ-024 SHALL, without WSCHED_STATS_EN, omit those ports and counters entirely.

Structure
REQ-025 SHALL place pixel_t (24-bit packed RGB), sched_state_t enum and SDRAM row/bank width constants in package hdmi_sdram_pkg.
REQ-026 SHALL implement the buffer as sub-module pixel_fifo (synchronous, single clock, data plus sof bit, count output).

Verification
REQ-027 SHALL cover: 8 pixels 0x000001..0x000008 with sof on first -> one request at bank0/row0/col0, wr_data 1..8 in order, then IDLE.
REQ-028 SHALL cover: 24 continuous pixels, wr_data_ready always high -> requests at col 0, 8, 16.
REQ-029 SHALL cover: wr_ack withheld 20 cycles with pix_valid held high -> FIFO fills to 16, pix_ready=0, no pixels lost or duplicated after ack.
REQ-030 SHALL cover: address at col 1016 (COL_BITS=10) -> next burst at col 0, row+1; at row 8191/col 1016 -> bank+1, row 0.
REQ-031 SHALL cover: pix_sof on the 3rd pixel of a burst -> misalign=1 and held until reset.
REQ-032 SHALL cover: reset_n pulsed low mid-DATA after 3 beats -> wr_req=0, wr_busy=0 at once; next burst starts at col 0.

Source files
------------

// File: rtl/hdmi_sdram_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hdmi_sdram_pkg : shared pixel type, scheduler states, SDRAM geometry     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package hdmi_sdram_pkg;

  localparam int PIX_BITS  = 24;
  localparam int ROW_BITS  = 13;
  localparam int BANK_BITS = 2;

  typedef logic [PIX_BITS-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/pixel_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pixel_fifo : single-clock FIFO of {sof, pixel} entries with fill count   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pixel_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 25
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_head,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int          AW     = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // A full FIFO still takes a new entry in the cycle it hands one out.
  assign w_pop  = i_pop & (r_count != '0);
  assign w_push = i_push & ((r_count != C_FULL) | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == C_FULL);
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/pixel_write_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pixel_write_scheduler : buffers pixels and issues SDRAM write bursts     |
// | Optional WSCHED_STATS_EN adds burst_count / stall_count outputs.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pixel_write_scheduler
  import hdmi_sdram_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int BURST_LEN  = 8,
  parameter int COL_BITS   = 10
) (
  input  logic                 SDRAM_CLK,
  input  logic                 reset_n,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  input  pixel_t               pix_data,
  input  logic                 pix_sof,
  output logic                 wr_req,
  input  logic                 wr_ack,
  output logic [BANK_BITS-1:0] wr_bank,
  output logic [ROW_BITS-1:0]  wr_row,
  output logic [COL_BITS-1:0]  wr_col,
  output pixel_t               wr_data,
  input  logic                 wr_data_ready,
  output logic                 wr_busy,
  output logic                 misalign
`ifdef WSCHED_STATS_EN
  ,
  output logic [15:0]          burst_count,
  output logic [15:0]          stall_count
`endif
);

  localparam int ADDR_BITS = BANK_BITS + ROW_BITS + COL_BITS;
  localparam int CW        = $clog2(FIFO_DEPTH) + 1;
  localparam int BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [CW-1:0]        C_BURST_CNT = CW'(BURST_LEN);
  localparam logic [BEAT_W-1:0]    C_LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [ADDR_BITS-1:0] C_STEP      = ADDR_BITS'(BURST_LEN);

  sched_state_t         r_state;
  logic [ADDR_BITS-1:0] r_addr;
  logic [BEAT_W-1:0]    r_beat;
  logic                 r_req;
  logic                 r_busy;
  logic                 r_misalign;
  logic                 r_run;

  logic [PIX_BITS:0]    w_head;
  logic                 w_head_sof;
  logic                 w_full;
  logic [CW-1:0]        w_count;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_burst_done;

  assign w_pop        = (r_state == DATA) & wr_data_ready;
  assign w_burst_done = w_pop & (r_beat == C_LAST_BEAT);
  assign pix_ready    = r_run & (~w_full | w_pop);
  assign w_push       = pix_valid & pix_ready;
  assign w_head_sof   = w_head[PIX_BITS];

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIX_BITS + 1)
  ) u_fifo (
    .clk     (SDRAM_CLK),
    .rst_n   (reset_n),
    .i_push  (w_push),
    .i_data  ({pix_sof, pix_data}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_count (w_count)
  );

  always_ff @(posedge SDRAM_CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_beat     <= '0;
      r_req      <= 1'b0;
      r_busy     <= 1'b0;
      r_misalign <= 1'b0;
      r_run      <= 1'b0;
    end else begin
      r_run <= 1'b1;
      // A frame start may only appear on the first beat of a burst.
      if (w_pop && w_head_sof && (r_beat != '0)) r_misalign <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_count >= C_BURST_CNT) begin
            r_state <= REQ;
            r_req   <= 1'b1;
            r_busy  <= 1'b1;
            r_beat  <= '0;
            if (w_head_sof) r_addr <= '0;
          end
        end
        REQ: begin
          if (wr_ack) begin
            r_state <= DATA;
            r_req   <= 1'b0;
          end
        end
        DATA: begin
          if (w_burst_done) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_beat  <= '0;
            // {bank,row,col} as one counter: col carries into row, row into bank.
            r_addr  <= r_addr + C_STEP;
          end else if (w_pop) begin
            r_beat <= r_beat + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_req   = r_req;
  assign wr_busy  = r_busy;
  assign misalign = r_misalign;
  assign wr_data  = (r_state == DATA) ? w_head[PIX_BITS-1:0] : '0;
  assign wr_col   = r_addr[COL_BITS-1:0];
  assign wr_row   = r_addr[COL_BITS +: ROW_BITS];
  assign wr_bank  = r_addr[COL_BITS+ROW_BITS +: BANK_BITS];

`ifdef WSCHED_STATS_EN
  logic [15:0] r_burst_count;
  logic [15:0] r_stall_count;

  always_ff @(posedge SDRAM_CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_burst_count <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_burst_done && (r_burst_count != 16'hFFFF)) r_burst_count <= r_burst_count + 16'd1;
      if (pix_valid && !pix_ready && (r_stall_count != 16'hFFFF)) r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign burst_count = r_burst_count;
  assign stall_count = r_stall_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pixel_write_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pixel_write_scheduler : directed bench with a queue-based model       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_pixel_write_scheduler;

  localparam int DEPTH = 16;
  localparam int BL    = 8;
  localparam int CB    = 10;
  localparam int AW    = 2 + 13 + CB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        pix_valid, pix_ready, pix_sof;
  logic [23:0] pix_data, wr_data;
  logic        wr_req, wr_ack, wr_data_ready, wr_busy, misalign;
  logic [1:0]  wr_bank;
  logic [12:0] wr_row;
  logic [CB-1:0] wr_col;

  logic        t_rst_n, t_pix_valid, t_pix_ready, t_pix_sof;
  logic [23:0] t_pix_data, t_wr_data;
  logic        t_wr_req, t_wr_ack, t_wr_data_ready, t_wr_busy, t_misalign;
  logic [1:0]  t_bank;
  logic [12:0] t_row;
  logic [0:0]  t_col;
`ifdef WSCHED_STATS_EN
  logic [15:0] burst_count, stall_count, t_burst_count, t_stall_count;
`endif

  pixel_write_scheduler #(.FIFO_DEPTH(DEPTH), .BURST_LEN(BL), .COL_BITS(CB)) dut (
    .SDRAM_CLK(clk), .reset_n(reset_n), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_sof(pix_sof), .wr_req(wr_req), .wr_ack(wr_ack),
    .wr_bank(wr_bank), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .wr_data_ready(wr_data_ready), .wr_busy(wr_busy), .misalign(misalign)
`ifdef WSCHED_STATS_EN
    , .burst_count(burst_count), .stall_count(stall_count)
`endif
  );

  // Narrow-column instance so the row->bank carry is reachable in a short run.
  pixel_write_scheduler #(.FIFO_DEPTH(4), .BURST_LEN(2), .COL_BITS(1)) tdut (
    .SDRAM_CLK(clk), .reset_n(t_rst_n), .pix_valid(t_pix_valid), .pix_ready(t_pix_ready),
    .pix_data(t_pix_data), .pix_sof(t_pix_sof), .wr_req(t_wr_req), .wr_ack(t_wr_ack),
    .wr_bank(t_bank), .wr_row(t_row), .wr_col(t_col), .wr_data(t_wr_data),
    .wr_data_ready(t_wr_data_ready), .wr_busy(t_wr_busy), .misalign(t_misalign)
`ifdef WSCHED_STATS_EN
    , .burst_count(t_burst_count), .stall_count(t_stall_count)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of buffered entries plus burst phase (0 idle, 1 request, 2 data).
  logic [24:0] mq[$];
  int     m_phase = 0, m_beats = 0, m_bursts = 0, m_stalls = 0, n_acc = 0;
  longint m_next = 0, m_cur = 0;
  bit     m_mis = 0, m_run = 0;
  longint req_log[$];
  longint beat_log[$];

  function automatic longint rl(input int i);
    return (i < req_log.size()) ? req_log[i] : -1;
  endfunction
  function automatic longint bl(input int i);
    return (i < beat_log.size()) ? beat_log[i] : -1;
  endfunction

  always @(negedge clk) begin : p_compare
    bit pop;
    bit exp_rdy;
    if (!reset_n) begin
      chk("rst_wr_req", wr_req, 0);
      chk("rst_wr_busy", wr_busy, 0);
      chk("rst_pix_ready", pix_ready, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_misalign", misalign, 0);
      mq.delete();
      m_phase = 0; m_beats = 0; m_next = 0; m_mis = 0; m_run = 0; m_bursts = 0; m_stalls = 0;
    end else begin
      pop     = (m_phase == 2) && wr_data_ready;
      exp_rdy = m_run && ((mq.size() < DEPTH) || pop);
      chk("pix_ready", pix_ready, exp_rdy);
      chk("wr_req", wr_req, m_phase == 1);
      chk("wr_busy", wr_busy, m_phase != 0);
      chk("misalign", misalign, m_mis);
`ifdef WSCHED_STATS_EN
      chk("burst_count", burst_count, (m_bursts > 65535) ? 65535 : m_bursts);
      chk("stall_count", stall_count, (m_stalls > 65535) ? 65535 : m_stalls);
`endif
      if (m_phase == 1) chk("wr_addr", {wr_bank, wr_row, wr_col}, m_cur);
      if (m_phase == 2) chk("wr_data", wr_data, (mq.size() > 0) ? longint'(mq[0][23:0]) : -1);
      if (wr_req && wr_ack) req_log.push_back(longint'({wr_bank, wr_row, wr_col}));
      if (wr_busy && !wr_req && wr_data_ready) beat_log.push_back(longint'(wr_data));
      if (pix_valid && pix_ready) n_acc++;
      if (pix_valid && !exp_rdy) m_stalls++;
      case (m_phase)
        0: if (mq.size() >= BL) begin
             m_phase = 1;
             m_cur   = mq[0][24] ? 0 : m_next;
           end
        1: if (wr_ack) begin
             m_phase = 2;
             m_beats = 0;
           end
        2: if (wr_data_ready && mq.size() > 0) begin
             if (mq[0][24] && m_beats != 0) m_mis = 1;
             void'(mq.pop_front());
             m_beats++;
             if (m_beats == BL) begin
               m_phase = 0;
               m_next  = (m_cur + BL) % (longint'(1) << AW);
               m_bursts++;
             end
           end
        default: m_phase = 0;
      endcase
      if (pix_valid && exp_rdy) mq.push_back({pix_sof, pix_data});
      m_run = 1;
    end
  end

  // SDRAM controller stand-in.
  int ack_delay = 0;
  bit rdy_en = 1;
  bit rdy_alt = 0;
  initial begin : p_responder
    int wait_cnt;
    wait_cnt = 0;
    wr_ack = 1'b0;
    wr_data_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (wr_req) begin
        wr_ack = (wait_cnt >= ack_delay);
        wait_cnt++;
      end else begin
        wr_ack = 1'b0;
        wait_cnt = 0;
      end
      wr_data_ready = rdy_alt ? ~wr_data_ready : rdy_en;
    end
  end

  task automatic send(input int n, input int base, input int sof_at);
    for (int i = 0; i < n; i++) begin
      int guard;
      bit done;
      guard = 0;
      done = 0;
      pix_valid = 1'b1;
      pix_data  = 24'(base + i);
      pix_sof   = (i == sof_at);
      while (!done) begin
        @(negedge clk);
        done = pix_ready;
        @(posedge clk); #1;
        guard++;
        if (!done && guard > 500) begin
          chk("send_timeout", i, n);
          pix_valid = 1'b0;
          pix_sof = 1'b0;
          return;
        end
      end
    end
    pix_valid = 1'b0;
    pix_sof = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    bit idle;
    g = 0;
    idle = 0;
    while (!idle) begin
      @(negedge clk);
      idle = !wr_busy && !wr_req && (mq.size() == 0);
      g++;
      if (!idle && g > 3000) begin
        chk("idle_timeout", g, 0);
        idle = 1;
      end
    end
    @(posedge clk); #1;
  endtask

  bit tiny_done = 0;

  initial begin : p_main
    int a0;
    int beats;
    int g;
    reset_n = 1'b1; pix_valid = 1'b0; pix_data = '0; pix_sof = 1'b0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pix_ready_lit", pix_ready, 0);
    chk("rst_wr_busy_lit", wr_busy, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_release", pix_ready, 1);

    // One frame-start burst of 1..8.
    req_log.delete(); beat_log.delete();
    send(8, 1, 0);
    wait_idle();
    chk("t1_req_cnt", req_log.size(), 1);
    chk("t1_addr", rl(0), 0);
    for (int i = 0; i < 8; i++) chk("t1_beat", bl(i), i + 1);
    chk("t1_idle", wr_busy, 0);

    // 24 continuous pixels: three bursts at col 0, 8, 16.
    req_log.delete(); beat_log.delete();
    send(24, 100, 0);
    wait_idle();
    chk("t2_req_cnt", req_log.size(), 3);
    chk("t2_col0", rl(0), 0);
    chk("t2_col8", rl(1), 8);
    chk("t2_col16", rl(2), 16);
    chk("t2_last_beat", bl(23), 123);

    // Ack withheld for 20 cycles while pixels keep coming.
    req_log.delete(); beat_log.delete();
    ack_delay = 20;
    a0 = n_acc;
    fork
      send(24, 200, -1);
      begin
        repeat (20) @(negedge clk);
        chk("t3_full_ready", pix_ready, 0);
        chk("t3_accepted", n_acc - a0, 16);
        chk("t3_req_held", wr_req, 1);
      end
    join
    wait_idle();
    ack_delay = 0;
    chk("t3_req_cnt", req_log.size(), 3);
    chk("t3_addr", rl(0), 24);
    chk("t3_beat_cnt", beat_log.size(), 24);
    chk("t3_beat_last", bl(23), 223);

    // Frame start on the third pixel of a burst, with a gappy consumer.
    rdy_alt = 1;
    send(8, 300, 2);
    wait_idle();
    chk("t4_misalign", misalign, 1);
    send(8, 400, -1);
    wait_idle();
    rdy_alt = 0;
    chk("t4_misalign_held", misalign, 1);

    // Column rollover: burst 127 at col 1016, burst 128 at row 1 col 0.
    req_log.delete();
    send(129 * 8, 24'h1000, 0);
    wait_idle();
    chk("t5_req_cnt", req_log.size(), 129);
    chk("t5_col1016", rl(127), 1016);
    chk("t5_row1", rl(128), 1 << CB);
    chk("t5_misalign_held", misalign, 1);

    // Reset three beats into a burst.
    rdy_en = 0;
    beat_log.delete();
    send(8, 500, -1);
    g = 0;
    while (!(wr_busy && !wr_req) && g < 100) begin @(negedge clk); g++; end
    chk("t6_in_data", wr_busy && !wr_req, 1);
    @(negedge clk);
    rdy_en = 1;
    beats = 0;
    g = 0;
    while (beats < 3 && g < 100) begin
      @(negedge clk);
      g++;
      if (wr_data_ready && wr_busy && !wr_req) beats++;
    end
    rdy_en = 0;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("t6_req_now", wr_req, 0);
    chk("t6_busy_now", wr_busy, 0);
    chk("t6_ready_now", pix_ready, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    rdy_en = 1;
    @(posedge clk); #1;
    chk("t6_beat_cnt", beat_log.size(), 3);
    chk("t6_beat2", bl(2), 502);
    chk("t6_misalign_clr", misalign, 0);
    req_log.delete();
    send(8, 600, -1);
    wait_idle();
    chk("t6_restart_col", rl(0), 0);

    wait (tiny_done);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Narrow instance: every request n must sit at row n%8192, bank n/8192.
  initial begin : p_tiny
    int n;
    int cyc;
    t_pix_valid = 1'b1; t_pix_sof = 1'b0; t_pix_data = '0;
    t_wr_ack = 1'b1; t_wr_data_ready = 1'b1;
    t_rst_n = 1'b1;
    #1 t_rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 t_rst_n = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 8193 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (t_wr_req) begin
        chk("tiny_addr", {t_bank, t_row, t_col}, (longint'(n) * 2) % 65536);
        if (n == 8191) begin
          chk("tiny_row_end", t_row, 8191);
          chk("tiny_bank_end", t_bank, 0);
        end
        if (n == 8192) begin
          chk("tiny_row_wrap", t_row, 0);
          chk("tiny_bank_inc", t_bank, 1);
        end
        n++;
      end
    end
    if (n < 8193) chk("tiny_timeout", n, 8193);
    tiny_done = 1;
  end

endmodule
`default_nettype wire
